// File: rtl/fixed_recip_nr.sv
// Pipelined signed fixed-point reciprocal: normalise, LUT seed, Newton-Raphson.
// Define FIXED_RECIP_ROUND_EN to round the final shift instead of truncating.
module fixed_recip_nr #(
  parameter int WIDTH    = 20,
  parameter int FRAC     = 8,
  parameter int ITERS    = 2,
  parameter int LUT_BITS = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             valid_in,
  input  logic [WIDTH-1:0] data_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             sat_out,
  output logic             div0_out
);

  localparam int FI   = WIDTH;
  localparam int YW   = FI + 2;
  localparam int PW   = $clog2(WIDTH);
  localparam int NS   = 2 * ITERS;
  localparam int EOFF = 2 * FRAC - 1 - FI;
  localparam int LSH  = (EOFF > 0) ? EOFF : 0;
  localparam int RW   = YW + LSH + 1;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};

  function automatic logic [YW-1:0] seed(input int k);
    logic [63:0] num;
    logic [63:0] den;
    num = 64'd1 << (FI + LUT_BITS + 2);
    den = 64'((2 << LUT_BITS) + 2 * k + 1);
    if (k == 0) return YW'(1) << (FI + 1);
    return YW'((num + (den >> 1)) / den);
  endfunction

  function automatic logic [YW-1:0] mul_t(
    input logic [FI-1:0] m,
    input logic [YW-1:0] y
  );
    logic [FI+YW-1:0] pr;
    pr = m * y;
    return YW'(pr >> FI);
  endfunction

  function automatic logic [YW-1:0] mul_y(
    input logic [YW-1:0] y,
    input logic [YW-1:0] t
  );
    logic [YW-1:0]   d;
    logic [2*YW-1:0] pr;
    d  = (YW'(1) << (FI + 1)) - t;
    pr = y * d;
    return YW'(pr >> FI);
  endfunction

  logic [YW-1:0] lut [2**LUT_BITS];
  for (genvar k = 0; k < 2**LUT_BITS; k++) begin : g_lut
    assign lut[k] = seed(k);
  end

  logic             s0_v, s0_sign;
  logic [WIDTH-1:0] s0_mag;

  always_ff @(posedge clk_in) begin
    if (rst_in) s0_v <= 1'b0;
    else        s0_v <= valid_in;
    s0_sign <= data_in[WIDTH-1];
    s0_mag  <= data_in[WIDTH-1] ? -data_in : data_in;
  end

  logic [PW-1:0]    lz_p;
  logic [WIDTH-1:0] norm;

  always_comb begin
    lz_p = '0;
    for (int i = 0; i < WIDTH; i++)
      if (s0_mag[i]) lz_p = PW'(i);
    norm = s0_mag << (PW'(WIDTH - 1) - lz_p);
  end

  logic             s1_v, s1_sign, s1_zero;
  logic [PW-1:0]    s1_p;
  logic [WIDTH-1:0] s1_m;

  always_ff @(posedge clk_in) begin
    if (rst_in) s1_v <= 1'b0;
    else        s1_v <= s0_v;
    s1_sign <= s0_sign;
    s1_zero <= (s0_mag == '0);
    s1_p    <= lz_p;
    s1_m    <= norm;
  end

  logic [LUT_BITS-1:0] idx;
  assign idx = s1_m[WIDTH-2 -: LUT_BITS];

  // Index 0 is the seed stage; even->odd computes t, odd->even updates y.
  logic [NS:0]      st_v, st_sign, st_zero;
  logic [PW-1:0]    st_p [NS+1];
  logic [WIDTH-1:0] st_m [NS+1];
  logic [YW-1:0]    st_y [NS+1];
  logic [YW-1:0]    st_t [NS+1];

  always_ff @(posedge clk_in) begin
    if (rst_in) st_v <= '0;
    else        st_v <= {st_v[NS-1:0], s1_v};
    st_sign[0] <= s1_sign;
    st_zero[0] <= s1_zero;
    st_p[0]    <= s1_p;
    st_m[0]    <= s1_m;
    st_y[0]    <= lut[idx];
    st_t[0]    <= '0;
    for (int i = 0; i < NS; i++) begin
      st_sign[i+1] <= st_sign[i];
      st_zero[i+1] <= st_zero[i];
      st_p[i+1]    <= st_p[i];
      st_m[i+1]    <= st_m[i];
      if (i % 2 == 0) begin
        st_t[i+1] <= mul_t(st_m[i], st_y[i]);
        st_y[i+1] <= st_y[i];
      end else begin
        st_t[i+1] <= st_t[i];
        st_y[i+1] <= mul_y(st_y[i], st_t[i]);
      end
    end
  end

  int            e, sh;
  logic [RW-1:0] yw, r;

  always_comb begin
    e  = EOFF - int'(st_p[NS]);
    yw = RW'(st_y[NS]);
    sh = 0;
    r  = '0;
    if (e >= 0) begin
      r = yw << e;
    end else begin
      sh = -e;
`ifdef FIXED_RECIP_ROUND_EN
      r = (yw + (RW'(1) << (sh - 1))) >> sh;
`else
      r = yw >> sh;
`endif
    end
  end

  logic          d_v, d_sign, d_zero;
  logic [RW-1:0] d_r;

  always_ff @(posedge clk_in) begin
    if (rst_in) d_v <= 1'b0;
    else        d_v <= st_v[NS];
    d_sign <= st_sign[NS];
    d_zero <= st_zero[NS];
    d_r    <= r;
  end

  logic             over;
  logic [WIDTH-1:0] mag;

  always_comb begin
    over = (d_r > RW'(MAXV));
    mag  = over ? MAXV : d_r[WIDTH-1:0];
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_out <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
      div0_out  <= 1'b0;
    end else begin
      valid_out <= d_v;
      if (d_zero) begin
        data_out <= MAXV;
        sat_out  <= 1'b1;
        div0_out <= 1'b1;
      end else begin
        data_out <= d_sign ? -mag : mag;
        sat_out  <= over;
        div0_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fixed_recip_nr.sv
// Directed and streaming bench for fixed_recip_nr.
// Honours FIXED_RECIP_ROUND_EN in its reference model.
module tb_fixed_recip_nr;

  localparam int NOPS = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [19:0] data_in;
  logic        valid_out;
  logic [19:0] data_out;
  logic        sat_out;
  logic        div0_out;

  logic        v16;
  logic [15:0] d16;
  logic        vo16;
  logic [15:0] do16;
  logic        sat16;
  logic        div16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_recip_nr dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .valid_in (valid_in),
    .data_in  (data_in),
    .valid_out(valid_out),
    .data_out (data_out),
    .sat_out  (sat_out),
    .div0_out (div0_out)
  );

  fixed_recip_nr #(.WIDTH(16), .FRAC(12)) dut16 (
    .clk_in   (clk),
    .rst_in   (rst),
    .valid_in (v16),
    .data_in  (d16),
    .valid_out(vo16),
    .data_out (do16),
    .sat_out  (sat16),
    .div0_out (div16)
  );

  logic [19:0] vx [9] = '{20'h00100, 20'h00200, 20'h00040,
                          20'hFFC00, 20'h00300, 20'hFFD00,
                          20'h00001, 20'h80000, 20'h00000};
  logic [19:0] vy [9] = '{20'h00100, 20'h00080, 20'h00400,
                          20'hFFFC0, 20'h00055, 20'hFFFAB,
                          20'h10000, 20'h00000, 20'h7FFFF};
  logic        vs [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};

  logic        hv [NOPS];
  logic [19:0] hd [NOPS];

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b1;
    data_in = 20'h00100;
    v16 = 1'b0;
    d16 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b want 0", valid_out);
    end
    checks++;
    if (data_out !== 20'h0) begin
      errors++; $display("FAIL reset_data got %h want 00000", data_out);
    end
    checks++;
    if (sat_out !== 1'b0 || div0_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got %b%b want 00", sat_out, div0_out);
    end
    checks++;
    if (vo16 !== 1'b0) begin
      errors++; $display("FAIL reset_valid16 got %b want 0", vo16);
    end
    rst = 1'b0;
    valid_in = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++; $display("FAIL reset_ignored_in got %b want 0", valid_out);
    end
  endtask

  task automatic test_directed();
    int lat;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in = vx[k];
      lat = 0;
      do begin
        @(negedge clk);
        if (lat == 0) valid_in = 1'b0;
        lat++;
      end while (!valid_out && lat < 20);
      checks++;
      if (!valid_out || lat - 1 != 8) begin
        errors++;
        $display("FAIL lat_%h got %0d want 8", vx[k], lat - 1);
      end
      checks++;
      if (data_out !== vy[k]) begin
        errors++;
        $display("FAIL data_%h got %h want %h", vx[k], data_out, vy[k]);
      end
      checks++;
      if (sat_out !== vs[k]) begin
        errors++;
        $display("FAIL sat_%h got %b want %b", vx[k], sat_out, vs[k]);
      end
      checks++;
      if (div0_out !== vs[k]) begin
        errors++;
        $display("FAIL div0_%h got %b want %b", vx[k], div0_out, vs[k]);
      end
    end
  endtask

  task automatic test_w16_sat();
    int lat;
    @(negedge clk);
    v16 = 1'b1;
    d16 = 16'h0001;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) v16 = 1'b0;
      lat++;
    end while (!vo16 && lat < 20);
    checks++;
    if (!vo16 || lat - 1 != 8) begin
      errors++; $display("FAIL w16_lat got %0d want 8", lat - 1);
    end
    checks++;
    if (do16 !== 16'h7FFF) begin
      errors++; $display("FAIL w16_data got %h want 7fff", do16);
    end
    checks++;
    if (sat16 !== 1'b1 || div16 !== 1'b0) begin
      errors++; $display("FAIL w16_flags got %b%b want 10", sat16, div16);
    end
  endtask

  task automatic test_stream();
    int j, q, ex, got, diff;
    logic [19:0] mag;
    for (int c = 0; c < NOPS + 9; c++) begin
      @(negedge clk);
      if (c >= 9) begin
        j = c - 9;
        checks++;
        if (valid_out !== hv[j]) begin
          errors++;
          $display("FAIL stream_valid[%0d] got %b want %b", j, valid_out, hv[j]);
        end else if (hv[j]) begin
          checks++;
          mag = hd[j][19] ? -hd[j] : hd[j];
          if (mag == 20'h0) begin
            if (data_out !== 20'h7FFFF || sat_out !== 1'b1 || div0_out !== 1'b1) begin
              errors++;
              $display("FAIL stream_zero[%0d] got %h %b%b want 7ffff 11",
                       j, data_out, sat_out, div0_out);
            end
          end else begin
`ifdef FIXED_RECIP_ROUND_EN
            q = (65536 + int'(mag) / 2) / int'(mag);
`else
            q = 65536 / int'(mag);
`endif
            ex = hd[j][19] ? -q : q;
            got = int'($signed(data_out));
            diff = got - ex;
            if (diff > 1 || diff < -1 || sat_out !== 1'b0 || div0_out !== 1'b0) begin
              errors++;
              $display("FAIL stream_data[%0d] x=%h got %0d flags %b%b want %0d+-1 flags 00",
                       j, hd[j], got, sat_out, div0_out, ex);
            end
          end
        end
      end
      if (c < NOPS) begin
        hv[c] = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) == 0) begin
          hd[c] = 20'($urandom_range(0, 1023));
          if ($urandom_range(0, 1) == 1) hd[c] = -hd[c];
        end else begin
          hd[c] = 20'($urandom);
        end
        valid_in = hv[c];
        data_in = hd[c];
      end else begin
        valid_in = 1'b0;
      end
    end
  endtask

  task automatic test_reset_midstream();
    int seen, lat;
    repeat (10) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      valid_in = 1'b1;
      data_in = 20'h00100 + 20'(k * 16);
    end
    @(negedge clk);
    rst = 1'b1;
    data_in = 20'h00100;
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 20'h0 ||
        sat_out !== 1'b0 || div0_out !== 1'b0) begin
      errors++;
      $display("FAIL midrst_outs got %b %h %b%b want 0 00000 00",
               valid_out, data_out, sat_out, div0_out);
    end
    seen = 0;
    repeat (14) begin
      @(negedge clk);
      if (valid_out) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL midrst_flush got %0d valids want 0", seen);
    end
    @(negedge clk);
    valid_in = 1'b1;
    data_in = 20'h00200;
    lat = 0;
    do begin
      @(negedge clk);
      if (lat == 0) valid_in = 1'b0;
      lat++;
    end while (!valid_out && lat < 20);
    checks++;
    if (!valid_out || lat - 1 != 8 || data_out !== 20'h00080) begin
      errors++;
      $display("FAIL midrst_next got lat %0d data %h want 8 00080",
               lat - 1, data_out);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_w16_sat();
    test_stream();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
